// File: rtl/shifter_pkg.sv
// Shared definitions for the iterative shifter: mode codes and FSM states.
package shifter_pkg;

    // Operation codes carried on MODE; anything above SH_ROR is a pass-through.
    localparam logic [2:0] SH_SLL = 3'b000;
    localparam logic [2:0] SH_SRL = 3'b001;
    localparam logic [2:0] SH_SRA = 3'b010;
    localparam logic [2:0] SH_ROL = 3'b011;
    localparam logic [2:0] SH_ROR = 3'b100;

    // ST_FIN is the cycle in which DONE is high; it also accepts a new request.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FIN   = 2'd2
    } state_t;

    // Pass codes shift by nothing and return the operand unchanged.
    function automatic logic is_pass(input logic [2:0] mode);
        return (mode > SH_ROR);
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single step: shifts W by k (0..STEP) positions according to mode.
module shift_step
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1,
    parameter int K_W   = $clog2(STEP) + 1
) (
    input  logic [WIDTH-1:0] w_i,
    input  logic [2:0]       mode_i,
    input  logic [K_W-1:0]   k_i,
    output logic [WIDTH-1:0] w_o
);

    logic [2*WIDTH-1:0] dbl_l;
    logic [2*WIDTH-1:0] dbl_r;

    // Rotates use a doubled word so the wrapped bits fall into the kept half.
    always_comb begin
        dbl_l = {w_i, w_i} << k_i;
        dbl_r = {w_i, w_i} >> k_i;
        case (mode_i)
            SH_SLL:  w_o = w_i << k_i;
            SH_SRL:  w_o = w_i >> k_i;
            SH_SRA:  w_o = $signed(w_i) >>> k_i;
            SH_ROL:  w_o = dbl_l[2*WIDTH-1:WIDTH];
            SH_ROR:  w_o = dbl_r[WIDTH-1:0];
            default: w_o = w_i;
        endcase
    end

endmodule

// File: rtl/shifter_iter.sv
// Multi-cycle shifter: up to STEP positions per clock, START/BUSY/DONE handshake.
// Handshake: a request is taken on a rising edge where START=1 and BUSY=0;
// BUSY stays high until the edge that loads OUT, which also raises DONE for
// exactly one cycle. START while BUSY=1 is ignored (no queueing).
module shifter_iter
    import shifter_pkg::*;
#(
    parameter  int WIDTH   = 32,
    parameter  int STEP    = 1,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               START,
    input  logic [2:0]         MODE,
    input  logic [SHAMT_W-1:0] SHAMT,
    input  logic [WIDTH-1:0]   IN,
    output logic [WIDTH-1:0]   OUT,
    output logic               BUSY,
    output logic               DONE,
    output logic [1:0]         DBG_STATE
);

    localparam int REM_W = SHAMT_W + 1;
    localparam int K_W   = $clog2(STEP) + 1;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   w_q, w_d;
    logic [REM_W-1:0]   rem_q, rem_d;
    logic [2:0]         mode_q, mode_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [K_W-1:0]     k;
    logic [WIDTH-1:0]   w_step;

    // Step size this cycle: a full STEP, or whatever is left if less.
    assign k = (rem_q > REM_W'(STEP)) ? K_W'(STEP) : rem_q[K_W-1:0];

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .K_W   (K_W)
    ) u_step (
        .w_i    (w_q),
        .mode_i (mode_q),
        .k_i    (k),
        .w_o    (w_step)
    );

    // Next-state logic: accept in IDLE/FIN, step in SHIFT, finish when REM hits 0.
    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        rem_d   = rem_q;
        mode_d  = mode_q;
        out_d   = out_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE, ST_FIN: begin
                state_d = ST_IDLE;
                if (START) begin
                    w_d     = IN;
                    mode_d  = MODE;
                    rem_d   = is_pass(MODE) ? '0 : {1'b0, SHAMT};
                    busy_d  = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (rem_q != '0) begin
                    w_d   = w_step;
                    rem_d = rem_q - REM_W'(k);
                end else begin
                    out_d   = w_q;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_FIN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset aborts any operation without a DONE pulse.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            w_q     <= '0;
            rem_q   <= '0;
            mode_q  <= '0;
            out_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            rem_q   <= rem_d;
            mode_q  <= mode_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign OUT       = out_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign DBG_STATE = state_q;

endmodule

// File: tb/tb_shifter_iter.sv
// Self-checking bench for shifter_iter across three width/step configurations.
module tb_shifter_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start_a, start_b, start_c;
  logic [2:0]  mode_v;
  logic [4:0]  shamt_v;
  logic [31:0] in_v;

  logic [31:0] out_a, out_b;
  logic [15:0] out_c;
  logic        busy_a, busy_b, busy_c;
  logic        done_a, done_b, done_c;
  logic [1:0]  dbg_a, dbg_b, dbg_c;

  int checks = 0;
  int errors = 0;
  int sel = 0;

  logic [31:0] out_m;
  logic        busy_m, done_m;

  // sel 0: WIDTH=32 STEP=1, sel 1: WIDTH=32 STEP=2, sel 2: WIDTH=16 STEP=4
  shifter_iter #(.WIDTH(32), .STEP(1)) u_a (
    .CLK(clk), .RST(rst), .START(start_a), .MODE(mode_v), .SHAMT(shamt_v),
    .IN(in_v), .OUT(out_a), .BUSY(busy_a), .DONE(done_a), .DBG_STATE(dbg_a)
  );
  shifter_iter #(.WIDTH(32), .STEP(2)) u_b (
    .CLK(clk), .RST(rst), .START(start_b), .MODE(mode_v), .SHAMT(shamt_v),
    .IN(in_v), .OUT(out_b), .BUSY(busy_b), .DONE(done_b), .DBG_STATE(dbg_b)
  );
  shifter_iter #(.WIDTH(16), .STEP(4)) u_c (
    .CLK(clk), .RST(rst), .START(start_c), .MODE(mode_v), .SHAMT(shamt_v[3:0]),
    .IN(in_v[15:0]), .OUT(out_c), .BUSY(busy_c), .DONE(done_c), .DBG_STATE(dbg_c)
  );

  always_comb begin
    out_m  = out_a;
    busy_m = busy_a;
    done_m = done_a;
    case (sel)
      1: begin out_m = out_b; busy_m = busy_b; done_m = done_b; end
      2: begin out_m = {16'h0, out_c}; busy_m = busy_c; done_m = done_c; end
      default: ;
    endcase
  end

  // Reference: each result bit is picked from its source bit position.
  function automatic logic [31:0] ref_shift(input int width, input int mode,
                                            input int shamt, input logic [31:0] din);
    logic [31:0] r;
    r = '0;
    if (mode > 4) return din;
    for (int i = 0; i < width; i++) begin
      case (mode)
        0: r[i] = (i >= shamt) ? din[i - shamt] : 1'b0;
        1: r[i] = (i + shamt < width) ? din[i + shamt] : 1'b0;
        2: r[i] = (i + shamt < width) ? din[i + shamt] : din[width - 1];
        3: r[i] = din[(i - shamt + width) % width];
        default: r[i] = din[(i + shamt) % width];
      endcase
    end
    return r;
  endfunction

  function automatic int ref_lat(input int step, input int mode, input int shamt);
    if (mode > 4 || shamt == 0) return 1;
    return (shamt + step - 1) / step + 1;
  endfunction

  function automatic int step_of(input int s);
    return (s == 0) ? 1 : (s == 1) ? 2 : 4;
  endfunction

  function automatic int width_of(input int s);
    return (s == 2) ? 16 : 32;
  endfunction

  task automatic set_start(input int s, input logic v);
    case (s)
      0: start_a = v;
      1: start_b = v;
      default: start_c = v;
    endcase
  endtask

  // Waits up to a bounded number of edges for DONE; lat = edges after acceptance.
  task automatic wait_done(output logic [31:0] res, output int lat);
    lat = -1;
    res = '0;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      if (done_m) begin
        lat = c;
        res = out_m;
        break;
      end
    end
    if (lat < 0) begin
      checks++; errors++;
      $display("FAIL done_timeout: sel=%0d no DONE within 200 cycles, required one", sel);
    end
  endtask

  // One request; inputs are scrambled right after acceptance to prove they are sampled.
  task automatic run_op(input int s, input logic [2:0] m, input int sh,
                        input logic [31:0] d, output logic [31:0] res, output int lat);
    sel = s;
    @(negedge clk);
    mode_v = m; shamt_v = sh[4:0]; in_v = d;
    set_start(s, 1'b1);
    @(posedge clk); #1;
    set_start(s, 1'b0);
    mode_v = 3'($urandom_range(0, 7));
    shamt_v = 5'($urandom_range(0, 31));
    in_v = $urandom;
    wait_done(res, lat);
  endtask

  task automatic test_reset;
    checks++; if (out_a !== 32'h0) begin errors++; $display("FAIL reset_out_a: got %h want 0", out_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy_a: got %b want 0", busy_a); end
    checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done_a: got %b want 0", done_a); end
    checks++; if (out_c !== 16'h0) begin errors++; $display("FAIL reset_out_c: got %h want 0", out_c); end
    checks++; if (busy_c !== 1'b0) begin errors++; $display("FAIL reset_busy_c: got %b want 0", busy_c); end
  endtask

  task automatic test_sll;
    logic [31:0] res;
    int lat;
    run_op(0, 3'b000, 31, 32'h0000_0001, res, lat);
    checks++; if (res !== 32'h8000_0000) begin errors++; $display("FAIL sll31_out: got %h want 80000000", res); end
    checks++; if (lat !== 32) begin errors++; $display("FAIL sll31_latency: got %0d want 32", lat); end
    @(posedge clk); #1;
    checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL done_one_cycle: got %b want 0", done_a); end
    repeat (4) @(posedge clk); #1;
    checks++; if (out_a !== 32'h8000_0000) begin errors++; $display("FAIL out_hold: got %h want 80000000", out_a); end
  endtask

  task automatic test_sra;
    logic [31:0] res;
    int lat;
    run_op(1, 3'b010, 4, 32'h8000_00F0, res, lat);
    checks++; if (res !== 32'hF800_000F) begin errors++; $display("FAIL sra_out: got %h want f800000f", res); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL sra_latency: got %0d want 3", lat); end
  endtask

  task automatic test_rotate;
    logic [31:0] res;
    int lat;
    run_op(0, 3'b100, 1, 32'h0000_0003, res, lat);
    checks++; if (res !== 32'h8000_0001) begin errors++; $display("FAIL ror_out: got %h want 80000001", res); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL ror_latency: got %0d want 2", lat); end
    run_op(0, 3'b011, 4, 32'h8000_0001, res, lat);
    checks++; if (res !== 32'h0000_0018) begin errors++; $display("FAIL rol_out: got %h want 00000018", res); end
    checks++; if (lat !== 5) begin errors++; $display("FAIL rol_latency: got %0d want 5", lat); end
  endtask

  task automatic test_pass_and_busy;
    logic [31:0] res, d;
    int lat;
    bit seen;
    d = $urandom;
    run_op(0, 3'b001, 0, d, res, lat);
    checks++; if (res !== d) begin errors++; $display("FAIL shamt0_out: got %h want %h", res, d); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL shamt0_latency: got %0d want 1", lat); end
    d = $urandom;
    run_op(0, 3'b111, 9, d, res, lat);
    checks++; if (res !== d) begin errors++; $display("FAIL pass_out: got %h want %h", res, d); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL pass_latency: got %0d want 1", lat); end
    // START pulse in the middle of a busy operation must be dropped.
    sel = 0;
    @(negedge clk);
    mode_v = 3'b000; shamt_v = 5'd10; in_v = 32'h5; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (3) @(posedge clk); #1;
    mode_v = 3'b111; shamt_v = 5'd0; in_v = 32'hDEAD_BEEF; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    wait_done(res, lat);
    checks++; if (res !== 32'h0000_1400) begin errors++; $display("FAIL busy_ignore_out: got %h want 00001400", res); end
    checks++; if (lat !== 7) begin errors++; $display("FAIL busy_ignore_latency: got %0d want 7", lat); end
    seen = 1'b0;
    repeat (15) begin @(posedge clk); #1; if (done_a) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL busy_ignore_extra_done: got %b want 0", seen); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] res;
    int lat;
    sel = 0;
    @(negedge clk);
    mode_v = 3'b000; shamt_v = 5'd2; in_v = 32'h1; start_a = 1'b1;
    @(posedge clk); #1;
    wait_done(res, lat);
    checks++; if (res !== 32'h4) begin errors++; $display("FAIL b2b_first_out: got %h want 4", res); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL b2b_first_latency: got %0d want 3", lat); end
    @(posedge clk); #1;
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL b2b_accept_busy: got %b want 1", busy_a); end
    checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL b2b_done_fall: got %b want 0", done_a); end
    start_a = 1'b0;
    wait_done(res, lat);
    checks++; if (res !== 32'h4) begin errors++; $display("FAIL b2b_second_out: got %h want 4", res); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL b2b_second_latency: got %0d want 3", lat); end
  endtask

  task automatic test_reset_midrun;
    bit seen;
    sel = 0;
    @(negedge clk);
    mode_v = 3'b000; shamt_v = 5'd20; in_v = 32'h0000_FFFF; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (5) @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (out_a !== 32'h0) begin errors++; $display("FAIL midrun_reset_out: got %h want 0", out_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL midrun_reset_busy: got %b want 0", busy_a); end
    seen = done_a;
    repeat (30) begin @(posedge clk); #1; if (done_a) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrun_reset_no_done: got %b want 0", seen); end
  endtask

  task automatic test_random(input int s, input int count);
    logic [31:0] res, d, exp_v;
    int lat, m, sh, w, exp_lat;
    w = width_of(s);
    for (int n = 0; n < count; n++) begin
      m  = $urandom_range(0, 7);
      sh = $urandom_range(0, w - 1);
      d  = (w == 16) ? ($urandom & 32'h0000_FFFF) : $urandom;
      exp_v   = ref_shift(w, m, sh, d);
      exp_lat = ref_lat(step_of(s), m, sh);
      run_op(s, 3'(m), sh, d, res, lat);
      checks++;
      if (res !== exp_v) begin
        errors++;
        $display("FAIL rand_out: sel=%0d mode=%0d shamt=%0d in=%h got %h want %h", s, m, sh, d, res, exp_v);
      end
      checks++;
      if (lat !== exp_lat) begin
        errors++;
        $display("FAIL rand_latency: sel=%0d mode=%0d shamt=%0d got %0d want %0d", s, m, sh, lat, exp_lat);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    mode_v = '0; shamt_v = '0; in_v = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_sll();
    test_sra();
    test_rotate();
    test_pass_and_busy();
    test_back_to_back();
    test_reset_midrun();
    test_random(2, 40);
    test_random(1, 20);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
